// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial stimulus path feeding the 101 detector.
package seq_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // Zero or an over-range length means "send the whole word".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with valid/ready load and bit-rate enable.
// Default order is LSB first; define SEQ_SERIALIZER_MSB_FIRST_EN for MSB first.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_next_c;
  logic [WIDTH-1:0] load_word_c;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_c;
  logic             ser_q;
  logic             cur_bit_c;
  logic             shift_c;
  logic             last_c;
  logic             accept_c;

  assign len_c    = LEN_W'(eff_len(32'(load_len), WIDTH));
  assign shift_c  = (state_q == S_SHIFT) && shift_en;
  assign last_c   = shift_c && (cnt_q == LEN_W'(1));
  assign accept_c = load_valid && load_ready;

`ifdef SEQ_SERIALIZER_MSB_FIRST_EN
  // Left-align the word so its top effective bit sits at the output end.
  assign load_word_c  = load_data << (WIDTH - 32'(len_c));
  assign cur_bit_c    = shreg_q[WIDTH-1];
  assign shreg_next_c = {shreg_q[WIDTH-2:0], 1'b0};
`else
  // Word is taken as-is; bit 0 leaves first.
  assign load_word_c  = load_data;
  assign cur_bit_c    = shreg_q[0];
  assign shreg_next_c = {1'b0, shreg_q[WIDTH-1:1]};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and decoded outputs; ready is combinational for zero-bubble reloads.
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    ser_valid  = 1'b0;
    done       = 1'b0;
    ser_out    = ser_q;
    case (state_q)
      S_IDLE: begin
        load_ready = !reset;
        if (accept_c) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy       = 1'b1;
        load_ready = !reset && last_c;
        ser_valid  = !reset && shift_c;
        done       = !reset && last_c;
        if (shift_c) ser_out = cur_bit_c;
        if (last_c && !accept_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift register, bit counter and held output bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
    end else begin
      if (shift_c) begin
        shreg_q <= shreg_next_c;
        cnt_q   <= cnt_q - LEN_W'(1);
        ser_q   <= cur_bit_c;
      end
      if (accept_c) begin
        shreg_q <= load_word_c;
        cnt_q   <= len_c;
      end
    end
  end

endmodule
